rat_alias_table: RTL and testbench

//  Register alias table (RAT) plus physical-tag free list; the write side of the RAT that rename_decoder reads.
//  - Allocates a new physical tag for each renamed destination.
//  - Tracks per-architectural-register done bits from writeback.
//  - Recycles tags released at retire.
//  - Drives rat_done/rat_aliases directly into rename_decoder.

---
 rtl/rat_pkg.sv | 21 ++
 rtl/rat_alias_table_tag_free_list.sv | 65 ++++++
 rtl/rat_alias_table.sv | 85 ++++++++
 tb/tb_rat_alias_table.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
// Shared parameters, types and reset helpers for the register alias table
// and its physical-tag free list.
package rat_pkg;

  localparam int NUM_ARCH  = 10;
  localparam int TAG_W     = 5;
  localparam int NUM_PHYS  = 1 << TAG_W;
  localparam int DEST_W    = 4;
  localparam int CNT_W     = TAG_W + 1;
  localparam int FREE_INIT = NUM_PHYS - 1 - NUM_ARCH;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam tag_t TAG_NONE = '0;

  function automatic tag_t reset_alias(input int i);
    return tag_t'(i + 1);
  endfunction

endpackage

// File: rtl/rat_alias_table_tag_free_list.sv
// Circular FIFO of free physical tags, preloaded at reset with the tags
// not aliased by any architectural register.
import rat_pkg::*;

module tag_free_list (
  input  logic clk,
  input  logic rst,
  input  logic pop,
  input  logic push,
  input  tag_t push_tag,
  output tag_t head_tag,
  output logic not_empty,
  output cnt_t count,
  output logic overflow
);

  tag_t mem [NUM_PHYS];
  tag_t head_q;
  tag_t tail_q;
  cnt_t cnt_q;
  logic ovf_q;

  logic do_pop;
  logic push_req;
  logic full;
  logic do_push;
  logic drop;

  assign full     = (cnt_q == cnt_t'(FREE_INIT));
  assign do_pop   = pop & (cnt_q != '0);
  assign push_req = push & (push_tag != TAG_NONE);
  assign do_push  = push_req & ~full;
  assign drop     = push_req & full;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_PHYS; k++) begin
        mem[k] <= (k < FREE_INIT) ? tag_t'(k + NUM_ARCH + 1)
                                  : TAG_NONE;
      end
      head_q <= '0;
      tail_q <= tag_t'(FREE_INIT);
      cnt_q  <= cnt_t'(FREE_INIT);
      ovf_q  <= 1'b0;
    end else begin
      if (do_pop) head_q <= head_q + 1'b1;
      if (do_push) begin
        mem[tail_q] <= push_tag;
        tail_q      <= tail_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign head_tag  = mem[head_q];
  assign not_empty = (cnt_q != '0);
  assign count     = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: rtl/rat_alias_table.sv
// Register alias table with done bits feeding rename_decoder.
// Define RAT_WB_BYPASS_EN for same-cycle writeback wakeup on rat_done.
import rat_pkg::*;

module rat_alias_table (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rename_valid,
  input  logic [DEST_W-1:0]         rename_dest,
  output logic                      rename_ready,
  output logic [TAG_W-1:0]          rename_tag,
  output logic [TAG_W-1:0]          rename_old_tag,
  input  logic                      wb_valid,
  input  logic [TAG_W-1:0]          wb_tag,
  input  logic                      ret_valid,
  input  logic [TAG_W-1:0]          ret_tag,
  output logic [NUM_ARCH-1:0]       rat_done,
  output logic [NUM_ARCH*TAG_W-1:0] rat_aliases,
  output logic [TAG_W:0]            free_count,
  output logic                      overflow_err
);

  localparam logic [DEST_W-1:0] DEST_LIM = DEST_W'(NUM_ARCH);

  tag_t                alias_q [NUM_ARCH];
  logic [NUM_ARCH-1:0] done_q;
  logic [NUM_ARCH-1:0] ren_hit;
  logic [NUM_ARCH-1:0] wb_hit;
  logic                fire;

  assign fire = rename_valid & rename_ready
              & (rename_dest < DEST_LIM);

  tag_free_list u_free (
    .clk       (clk),
    .rst       (rst),
    .pop       (fire),
    .push      (ret_valid),
    .push_tag  (ret_tag),
    .head_tag  (rename_tag),
    .not_empty (rename_ready),
    .count     (free_count),
    .overflow  (overflow_err)
  );

  always_comb begin
    rename_old_tag = TAG_NONE;
    rat_aliases    = '0;
    ren_hit        = '0;
    wb_hit         = '0;
    for (int i = 0; i < NUM_ARCH; i++) begin
      ren_hit[i] = fire & (rename_dest == DEST_W'(i));
      wb_hit[i]  = wb_valid & (wb_tag != TAG_NONE)
                 & (alias_q[i] == wb_tag);
      if (rename_dest == DEST_W'(i)) rename_old_tag = alias_q[i];
      rat_aliases[i*TAG_W +: TAG_W] = alias_q[i];
    end
  end

  // Rename beats writeback: the new alias has not been produced yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        alias_q[i] <= reset_alias(i);
      end
      done_q <= '1;
    end else begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        if (ren_hit[i]) begin
          alias_q[i] <= rename_tag;
          done_q[i]  <= 1'b0;
        end else if (wb_hit[i]) begin
          done_q[i]  <= 1'b1;
        end
      end
    end
  end

`ifdef RAT_WB_BYPASS_EN
  assign rat_done = done_q | (wb_hit & ~ren_hit);
`else
  assign rat_done = done_q;
`endif

endmodule

// File: tb/tb_rat_alias_table.sv
// Randomized and directed checks of rat_alias_table against a
// queue-based reference model of the alias table and free list.
module tb_rat_alias_table;
  import rat_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      rename_valid;
  logic [DEST_W-1:0]         rename_dest;
  logic                      rename_ready;
  logic [TAG_W-1:0]          rename_tag;
  logic [TAG_W-1:0]          rename_old_tag;
  logic                      wb_valid;
  logic [TAG_W-1:0]          wb_tag;
  logic                      ret_valid;
  logic [TAG_W-1:0]          ret_tag;
  logic [NUM_ARCH-1:0]       rat_done;
  logic [NUM_ARCH*TAG_W-1:0] rat_aliases;
  logic [TAG_W:0]            free_count;
  logic                      overflow_err;

  rat_alias_table dut (
    .clk            (clk),
    .rst            (rst),
    .rename_valid   (rename_valid),
    .rename_dest    (rename_dest),
    .rename_ready   (rename_ready),
    .rename_tag     (rename_tag),
    .rename_old_tag (rename_old_tag),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .ret_valid      (ret_valid),
    .ret_tag        (ret_tag),
    .rat_done       (rat_done),
    .rat_aliases    (rat_aliases),
    .free_count     (free_count),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_alias [NUM_ARCH];
  bit m_done  [NUM_ARCH];
  int m_q     [$];
  int m_old   [$];
  bit m_ovf;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ARCH; i++) begin
      m_alias[i] = i + 1;
      m_done[i]  = 1'b1;
    end
    m_q.delete();
    m_old.delete();
    for (int t = NUM_ARCH + 1; t < NUM_PHYS; t++) m_q.push_back(t);
    m_ovf = 1'b0;
  endtask

  function automatic bit model_fire();
    return rename_valid && (m_q.size() != 0)
        && (int'(rename_dest) < NUM_ARCH);
  endfunction

  task automatic check_state();
    logic [NUM_ARCH-1:0]       exp_done;
    logic [NUM_ARCH*TAG_W-1:0] exp_alias;
    bit                        f;
    f = model_fire();
    for (int i = 0; i < NUM_ARCH; i++) begin
      exp_done[i] = m_done[i];
`ifdef RAT_WB_BYPASS_EN
      if (wb_valid && wb_tag != 0 && m_alias[i] == int'(wb_tag)
          && !(f && int'(rename_dest) == i))
        exp_done[i] = 1'b1;
`endif
      exp_alias[i*TAG_W +: TAG_W] = TAG_W'(m_alias[i]);
    end
    check("ready", 64'(rename_ready), 64'(m_q.size() != 0));
    check("count", 64'(free_count), 64'(m_q.size()));
    check("ovf", 64'(overflow_err), 64'(m_ovf));
    check("done", 64'(rat_done), 64'(exp_done));
    check("aliases", 64'(rat_aliases), 64'(exp_alias));
    if (m_q.size() != 0)
      check("ren_tag", 64'(rename_tag), 64'(m_q[0]));
    if (int'(rename_dest) < NUM_ARCH)
      check("old_tag", 64'(rename_old_tag),
            64'(m_alias[rename_dest]));
  endtask

  task automatic drive(input logic rv, input int dest,
                       input logic wv, input int wt,
                       input logic tv, input int tt);
    @(negedge clk);
    rename_valid = rv;
    rename_dest  = DEST_W'(dest);
    wb_valid     = wv;
    wb_tag       = TAG_W'(wt);
    ret_valid    = tv;
    ret_tag      = TAG_W'(tt);
    #1;
    check_state();
  endtask

  // Apply the cycle's events to the model, then let the edge happen.
  task automatic commit();
    bit f;
    int sz;
    int d;
    f  = model_fire();
    sz = m_q.size();
    d  = int'(rename_dest);
    if (wb_valid && wb_tag != 0)
      for (int i = 0; i < NUM_ARCH; i++)
        if (m_alias[i] == int'(wb_tag)) m_done[i] = 1'b1;
    if (f) begin
      m_old.push_back(m_alias[d]);
      m_alias[d] = m_q.pop_front();
      m_done[d]  = 1'b0;
    end
    if (ret_valid && ret_tag != 0) begin
      if (sz == FREE_INIT) m_ovf = 1'b1;
      else m_q.push_back(int'(ret_tag));
    end
    @(posedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
    commit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    rename_valid = 1'b0;
    wb_valid     = 1'b0;
    ret_valid    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst          = 1'b1;
    rename_valid = 1'b0;
    rename_dest  = '0;
    wb_valid     = 1'b0;
    wb_tag       = '0;
    ret_valid    = 1'b0;
    ret_tag      = '0;
    model_reset();

    do_reset();
    drive(0, 0, 0, 0, 0, 0);
    check("t1_done", 64'(rat_done), 64'h3FF);
    check("t1_count", 64'(free_count), 64'd21);
    check("t1_alias9", 64'(rat_aliases[9*TAG_W +: TAG_W]), 64'd10);
    commit();

    drive(1, 2, 0, 0, 0, 0);
    check("t2_tag", 64'(rename_tag), 64'd11);
    check("t2_old", 64'(rename_old_tag), 64'd3);
    commit();
    drive(0, 0, 1, 11, 0, 0);
    check("t2_alias2", 64'(rat_aliases[2*TAG_W +: TAG_W]), 64'd11);
    check("t2_count", 64'(free_count), 64'd20);
`ifndef RAT_WB_BYPASS_EN
    check("t3_wb_cycle", 64'(rat_done[2]), 64'd0);
`else
    check("t3_wb_cycle", 64'(rat_done[2]), 64'd1);
`endif
    commit();
    drive(0, 0, 0, 0, 0, 0);
    check("t3_done2", 64'(rat_done[2]), 64'd1);
    commit();

    do_reset();
    for (int i = 0; i < FREE_INIT; i++) begin
      drive(1, i % NUM_ARCH, 0, 0, 0, 0);
      commit();
    end
    drive(1, 0, 0, 0, 0, 0);
    check("t4_empty", 64'(rename_ready), 64'd0);
    commit();
    drive(0, 0, 0, 0, 1, 3);
    check("t4_stall", 64'(rename_ready), 64'd0);
    commit();
    drive(1, 5, 0, 0, 0, 0);
    check("t4_ready", 64'(rename_ready), 64'd1);
    check("t4_grant", 64'(rename_tag), 64'd3);
    commit();
    idle();

    do_reset();
    drive(1, 4, 1, 5, 0, 0);
    commit();
    drive(0, 0, 0, 0, 0, 0);
    check("t5_alias4", 64'(rat_aliases[4*TAG_W +: TAG_W]), 64'd11);
    check("t5_done4", 64'(rat_done[4]), 64'd0);
    commit();

    do_reset();
    drive(0, 0, 0, 0, 1, 5);
    commit();
    drive(0, 0, 0, 0, 0, 0);
    check("t6_ovf", 64'(overflow_err), 64'd1);
    check("t6_count", 64'(free_count), 64'd21);
    commit();
    do_reset();
    drive(0, 0, 0, 0, 1, 0);
    commit();
    drive(0, 0, 0, 0, 0, 0);
    check("t6_zero", 64'(overflow_err), 64'd0);
    commit();

    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int  d;
      int  wt;
      int  tt;
      bit  tv;
      if (n == 1500) do_reset();
      d  = int'($urandom_range(0, 11));
      wt = ($urandom % 2 == 0) ? m_alias[$urandom_range(0, NUM_ARCH-1)]
                               : int'($urandom_range(0, NUM_PHYS-1));
      tv = 1'b0;
      tt = 0;
      if (m_old.size() != 0 && $urandom % 3 == 0) begin
        tv = 1'b1;
        tt = m_old.pop_front();
      end else if ($urandom % 40 == 0) begin
        tv = 1'b1;
        tt = int'($urandom_range(0, NUM_PHYS-1));
      end
      drive(logic'($urandom % 4 != 0), d,
            logic'($urandom % 2), wt, tv, tt);
      commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
